instruction_encoder: RTL

//  Packs RV32I instruction fields and a 32-bit immediate into an instruction word;
//  the inverse of the core's immediate decode path.

---
 rtl/instruction_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// RV32I instruction packer: fields plus 32-bit immediate in, one instruction word out.
// Immediates are range-checked; the LI pseudo-op expands to ADDI or LUI(+ADDI).
module instruction_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err
);

  localparam logic [2:0] FmtR  = 3'd0;
  localparam logic [2:0] FmtI  = 3'd1;
  localparam logic [2:0] FmtS  = 3'd2;
  localparam logic [2:0] FmtB  = 3'd3;
  localparam logic [2:0] FmtU  = 3'd4;
  localparam logic [2:0] FmtJ  = 3'd5;
  localparam logic [2:0] FmtLi = 3'd6;

  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpOpImm  = 7'h13;

  typedef enum logic [0:0] {StIdle, StLiLo} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic        out_err_q, out_err_d;
  logic [4:0]  li_rd_q, li_rd_d;
  logic [11:0] li_lo_q, li_lo_d;

  logic signed [31:0] imm_s;
  logic [31:0]        li_sum;
  logic               imm_fits12;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic               enc_li_two;
  logic               out_free;

  assign imm_s      = $signed(in_imm);
  assign li_sum     = in_imm + 32'h0000_0800;
  assign imm_fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);

  always_comb begin
    enc_word   = NOP_WORD;
    enc_err    = 1'b0;
    enc_li_two = 1'b0;
    case (in_fmt)
      FmtR: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FmtI: begin
        enc_err  = !imm_fits12;
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FmtS: begin
        enc_err  = !imm_fits12;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FmtB: begin
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
      end
      FmtU: begin
        enc_err  = (in_imm[11:0] != 12'd0);
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      end
      FmtJ: begin
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      FmtLi: begin
        if (imm_fits12) begin
          enc_word = {in_imm[11:0], 5'd0, 3'd0, in_rd, OpOpImm};
        end else begin
          // hi is rounded so that the sign-extended ADDI of lo lands on the exact value
          enc_word   = {li_sum[31:12], in_rd, OpLui};
          enc_li_two = (in_imm[11:0] != 12'd0);
        end
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) begin
      enc_word = NOP_WORD;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    li_rd_d     = li_rd_q;
    li_lo_d     = li_lo_q;
    out_free    = !out_valid_q || out_ready;
    in_ready    = rst_n && (state_q == StIdle) && out_free;

    if (state_q == StLiLo) begin
      // LUI sits in the output stage here, so out_free means it was just taken
      if (out_free) begin
        out_valid_d = 1'b1;
        out_word_d  = {li_lo_q, li_rd_q, 3'd0, li_rd_q, OpOpImm};
        out_err_d   = 1'b0;
        state_d     = StIdle;
      end
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      out_word_d  = enc_word;
      out_err_d   = enc_err;
      if (enc_li_two) begin
        state_d = StLiLo;
        li_rd_d = in_rd;
        li_lo_d = in_imm[11:0];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_err_q   <= 1'b0;
      li_rd_q     <= 5'd0;
      li_lo_q     <= 12'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      li_rd_q     <= li_rd_d;
      li_lo_q     <= li_lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;

endmodule
